wave_capture: RTL

Writer side of the double-buffered 512-entry sample RAM that the wave display reads. Watches the audio sample stream, arms on a positive-going zero crossing, writes 256 consecutive 8-bit samples into the half of the RAM the display is not reading, then waits for the display to go idle and flips the buffer select. It sits between the codec sample path and the sample RAM write port. `read_index` drives the display's buffer-select input.

---
 rtl/wave_capture_if.sv | 24 ++
 rtl/wave_capture.sv | 94 +++++++++
 2 files changed

// File: rtl/wave_capture_if.sv
// Sample-stream input and RAM write-port bundle for the wave capture writer.
// master = the capture block, slave = the codec/display/RAM side.
interface wave_capture_if #(
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 8
);
  logic                       new_sample_ready;
  logic signed [SAMPLE_W-1:0] new_sample_in;
  logic                       wave_display_idle;
  logic [DEPTH_LOG2:0]        write_address;
  logic                       write_enable;
  logic [7:0]                 write_sample;
  logic                       read_index;

  modport master (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );

  modport slave (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Double-buffered wave capture writer: triggers on a positive zero crossing,
// fills the back half of the sample RAM, then flips halves on display idle.
module wave_capture #(
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.master bus
);
  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

  state_t                state, state_n;
  logic [DEPTH_LOG2-1:0] count, count_n;
  logic [SAMPLE_W-1:0]   prev_sample;
  logic                  idle_d;
  logic                  read_index, read_index_n;
  logic                  write_enable, write_enable_n;
  logic [DEPTH_LOG2:0]   write_address, write_address_n;
  logic [7:0]            write_sample, write_sample_n;
  logic                  idle_rise, crossing, strobe;
  logic [7:0]            conv;

  assign strobe    = bus.new_sample_ready;
  assign idle_rise = bus.wave_display_idle & ~idle_d;
  assign crossing  = prev_sample[SAMPLE_W-1] & ~bus.new_sample_in[SAMPLE_W-1];
  // Signed to offset-binary: keep the top byte, flip its sign bit.
  assign conv      = {~bus.new_sample_in[SAMPLE_W-1], bus.new_sample_in[SAMPLE_W-2 -: 7]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_ARMED;
      count         <= '0;
      prev_sample   <= '0;
      idle_d        <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      idle_d        <= bus.wave_display_idle;
      read_index    <= read_index_n;
      write_enable  <= write_enable_n;
      write_address <= write_address_n;
      write_sample  <= write_sample_n;
      if (strobe) prev_sample <= bus.new_sample_in;
    end
  end

  always_comb begin
    state_n         = state;
    count_n         = count;
    read_index_n    = read_index;
    write_enable_n  = 1'b0;
    write_address_n = write_address;
    write_sample_n  = write_sample;
    case (state)
      S_ARMED: begin
        // count is always 0 here: reset value, or wrapped by the last write
        if (strobe && crossing) begin
          write_enable_n  = 1'b1;
          write_address_n = {~read_index, {DEPTH_LOG2{1'b0}}};
          write_sample_n  = conv;
          count_n         = DEPTH_LOG2'(1);
          state_n         = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (strobe) begin
          write_enable_n  = 1'b1;
          write_address_n = {~read_index, count};
          write_sample_n  = conv;
          count_n         = count + 1'b1;
          if (count == {DEPTH_LOG2{1'b1}}) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Rises seen while armed or capturing are dropped; only a fresh one flips.
        if (idle_rise) begin
          read_index_n = ~read_index;
          state_n      = S_ARMED;
        end
      end
      default: state_n = S_ARMED;
    endcase
  end

  assign bus.write_enable  = write_enable;
  assign bus.write_address = write_address;
  assign bus.write_sample  = write_sample;
  assign bus.read_index    = read_index;
endmodule
